lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter ADDR_LIMIT, default 32'h0000_1000, is the exclusive upper bound of the byte addresses the data RAM decodes.
REQ-002 clk  in  1  system clock; all state updates on posedge clk.
REQ-003 clr  in  1  reset, synchronous, active-high, same net that clears the data RAM.
REQ-004 req_valid  in  1  CPU memory request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_signed  in  1  sign-extend load result (lb/lh); ignored for word and stores.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  out  1  response present.
REQ-012 resp_ready  in  1  CPU accepts the response.
REQ-013 resp_rdata  out  32  load result, already extended; 0 for stores and errors.
REQ-014 resp_err  out  1  request rejected: misaligned, out of range or illegal size.
REQ-015 ram_addr  out  12  byte address to the data RAM.
REQ-016 ram_mode  out  2  RAM access mode: 00 byte, 01 halfword, 10 word.
REQ-017 ram_we  out  1  RAM write enable.
REQ-018 ram_wdata  out  32  RAM write data.
REQ-019 ram_rdata  in  32  RAM combinational read data, right-aligned and zero-filled above the access size.
REQ-020 load_cnt, store_cnt, err_cnt  out  16 each  completed load, store and error counts.

Function
REQ-021 The FSM has three states: IDLE, ACCESS and RESP.
REQ-022 req_ready is 1 only in IDLE.
REQ-023 IDLE with req_valid: capture we, size, signed, addr and wdata, then check legality.
  - Legal request -> ACCESS.
  - Illegal request -> RESP with resp_err=1, with no RAM cycle.
REQ-024 A request is illegal when any of these holds:
  - size = 11;
  - halfword with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= ADDR_LIMIT.
REQ-025 The ACCESS state lasts exactly one cycle.
  - ram_addr = addr_q[11:0], ram_mode = size_q, ram_wdata = wdata_q.
  - ram_we = we_q & ~clr.
  - The result is registered into resp_rdata and the FSM goes to RESP.
REQ-026 Outside ACCESS: ram_we = 0, ram_mode = 10, ram_addr = addr_q[11:0], ram_wdata = wdata_q.
REQ-027 Load extension of ram_rdata:
  - byte: bit 7 replicated into [31:8] if signed_q, else zeros;
  - halfword: bit 15 replicated into [31:16] if signed_q, else zeros;
  - word: passed unchanged.
REQ-028 In RESP, resp_valid = 1 and resp_rdata / resp_err are held stable until resp_ready = 1; then the FSM returns to IDLE on that edge.
REQ-029 Latency:
  - Legal request accepted at edge N -> resp_valid first high in the cycle after edge N+1.
  - Error accepted at edge N -> resp_valid high in the cycle after edge N.
  - resp_ready held at 1 -> one request per 3 cycles (legal) or per 2 cycles (error).
REQ-030 No new request is accepted while a response is pending; req_valid outside IDLE is ignored and must be held by the CPU.
REQ-031 On leaving RESP via resp_ready, increment exactly one counter: err_cnt if resp_err, else store_cnt if we_q, else load_cnt.
REQ-032 load_cnt and store_cnt wrap FFFF -> 0000; err_cnt saturates at FFFF.
REQ-033 Store responses return resp_rdata = 0 and resp_err = 0.

Reset
REQ-034 clr high at a posedge clears the unit on that edge: state = IDLE, all captured registers = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, and all counters = 0.
REQ-035 clr asserted while in ACCESS suppresses ram_we in that cycle, the in-flight request is dropped with no response, and no counter increments.
REQ-036 After clr deasserts, req_ready = 1 in the first cycle.

Verification
REQ-037 Signed byte load: RAM word 0x0 = 32'h80FF_7F01, request lb at addr 0x003 -> resp_rdata = 32'hFFFF_FF80; same request with lbu -> 32'h0000_0080.
REQ-038 Halfword store then load: sh wdata 32'h1234_ABCD at addr 0x006, then lh at 0x006 -> ram_we high for exactly one cycle with ram_mode = 01, then resp_rdata = 32'hFFFF_ABCD; store_cnt = 1, load_cnt = 1.
REQ-039 Misaligned and out-of-range requests: lw at 0x002, lh at 0x001 and lw at 0x1000 -> each gives resp_err = 1, resp_rdata = 0, resp_valid one cycle after accept, ram_we never high, and err_cnt = 3.
REQ-040 Back-pressure: hold resp_ready = 0 for 5 cycles after resp_valid rises -> resp_rdata stable, req_ready = 0 throughout, and a req_valid presented meanwhile is not accepted.
REQ-041 Reset mid-operation: assert clr in the ACCESS cycle of sw 32'hDEAD_BEEF at 0x010 -> ram_we = 0 in that cycle, no resp_valid, all counters 0, and req_ready = 1 the cycle after clr falls.
REQ-042 Counter boundaries: preload err_cnt to FFFF via 65535 errors, issue one more error -> err_cnt stays FFFF; 65536 loads -> load_cnt = 0000.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between the CPU request port and a byte-addressed data RAM.
// Each request is legality-checked when accepted, makes at most one RAM cycle, and is held in RESP until the CPU takes it.
module lsu_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [11:0]      ram_addr,
    output logic [1:0]       ram_mode,
    output logic             ram_we,
    output logic [31:0]      ram_wdata,
    input  logic [31:0]      ram_rdata,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t           r_state;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [11:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_respValid;
    logic             r_respErr;
    logic [31:0]      r_respRdata;
    logic [CNT_W-1:0] r_loadCnt;
    logic [CNT_W-1:0] r_storeCnt;
    logic [CNT_W-1:0] r_errCnt;

    logic             w_illegal;
    logic [31:0]      w_loadData;
    logic             w_inAccess;

    // Only the RAM's 12-bit byte index is kept; range is judged on the full incoming address.
    always_comb begin
        w_illegal = 1'b0;
        case (req_size)
            SIZE_BYTE: w_illegal = 1'b0;
            SIZE_HALF: w_illegal = req_addr[0];
            SIZE_WORD: w_illegal = (req_addr[1:0] != 2'b00);
            SIZE_BAD:  w_illegal = 1'b1;
            default:   w_illegal = 1'b1;
        endcase
        if (req_addr >= ADDR_LIMIT) begin
            w_illegal = 1'b1;
        end
    end

    always_comb begin
        w_loadData = ram_rdata;
        case (r_size)
            SIZE_BYTE: w_loadData = {{24{r_signed & ram_rdata[7]}}, ram_rdata[7:0]};
            SIZE_HALF: w_loadData = {{16{r_signed & ram_rdata[15]}}, ram_rdata[15:0]};
            default:   w_loadData = ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed    <= 1'b0;
            r_addr      <= 12'h000;
            r_wdata     <= 32'h0000_0000;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= 32'h0000_0000;
            r_loadCnt   <= '0;
            r_storeCnt  <= '0;
            r_errCnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr[11:0];
                        r_wdata  <= req_wdata;
                        if (w_illegal) begin
                            r_respValid <= 1'b1;
                            r_respErr   <= 1'b1;
                            r_respRdata <= 32'h0000_0000;
                            r_state     <= RESP;
                        end else begin
                            r_state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_respValid <= 1'b1;
                    r_respErr   <= 1'b0;
                    r_respRdata <= r_we ? 32'h0000_0000 : w_loadData;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Errors saturate so a storm of bad requests never looks like zero.
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_state     <= IDLE;
                        if (r_respErr) begin
                            if (r_errCnt != '1) begin
                                r_errCnt <= r_errCnt + 1'b1;
                            end
                        end else if (r_we) begin
                            r_storeCnt <= r_storeCnt + 1'b1;
                        end else begin
                            r_loadCnt <= r_loadCnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_inAccess = (r_state == ACCESS);

    // clr gates the write strobe directly so a reset in the ACCESS cycle never corrupts RAM.
    assign ram_we     = w_inAccess & r_we & ~clr;
    assign ram_mode   = w_inAccess ? r_size : SIZE_WORD;
    assign ram_addr   = r_addr;
    assign ram_wdata  = r_wdata;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_respValid;
    assign resp_err   = r_respErr;
    assign resp_rdata = r_respRdata;
    assign load_cnt   = r_loadCnt;
    assign store_cnt  = r_storeCnt;
    assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: drives a full-width lsu_ctrl and a 4-bit-counter copy in lockstep against a byte-array RAM,
// comparing every response and counter against a byte-level reference memory and counting model.
module tb_lsu_ctrl;
    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic [31:0] ram_rdata;

    logic        req_ready, resp_valid, resp_err, ram_we;
    logic [31:0] resp_rdata, ram_wdata;
    logic [11:0] ram_addr;
    logic [1:0]  ram_mode;
    logic [15:0] load_cnt, store_cnt, err_cnt;

    logic        nReqReady, nRespValid, nRespErr, nRamWe;
    logic [31:0] nRespRdata, nRamWdata;
    logic [11:0] nRamAddr;
    logic [1:0]  nRamMode;
    logic [NW-1:0] nLoadCnt, nStoreCnt, nErrCnt;

    logic [7:0]  ram [0:4095];
    logic [7:0]  modelMem [0:4095];

    int checks = 0;
    int failures = 0;
    int weCount = 0;
    int nWeCount = 0;
    logic [45:0] weInfo;
    logic [45:0] nWeInfo;
    int expLoad, expStore, expErr, nExpLoad, nExpStore, nExpErr;
    logic [31:0] obsData;

    lsu_ctrl dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_addr(ram_addr), .ram_mode(ram_mode), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .load_cnt(load_cnt), .store_cnt(store_cnt), .err_cnt(err_cnt)
    );

    lsu_ctrl #(.CNT_W(NW)) dutNarrow (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(nReqReady), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(nRespValid), .resp_ready(resp_ready), .resp_rdata(nRespRdata), .resp_err(nRespErr),
        .ram_addr(nRamAddr), .ram_mode(nRamMode), .ram_we(nRamWe), .ram_wdata(nRamWdata), .ram_rdata(ram_rdata),
        .load_cnt(nLoadCnt), .store_cnt(nStoreCnt), .err_cnt(nErrCnt)
    );

    always #5 clk = ~clk;

    // Little-endian byte RAM, cleared by the same clr net as the unit.
    always_comb begin
        case (ram_mode)
            2'b00:   ram_rdata = {24'h0, ram[ram_addr]};
            2'b01:   ram_rdata = {16'h0, ram[ram_addr + 12'd1], ram[ram_addr]};
            default: ram_rdata = {ram[ram_addr + 12'd3], ram[ram_addr + 12'd2], ram[ram_addr + 12'd1], ram[ram_addr]};
        endcase
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
        end else if (ram_we) begin
            ram[ram_addr] <= ram_wdata[7:0];
            if (ram_mode != 2'b00) ram[ram_addr + 12'd1] <= ram_wdata[15:8];
            if (ram_mode == 2'b10) begin
                ram[ram_addr + 12'd2] <= ram_wdata[23:16];
                ram[ram_addr + 12'd3] <= ram_wdata[31:24];
            end
        end
    end

    // Write strobes are sampled mid-cycle, after the driver has updated inputs at the falling edge.
    always @(negedge clk) begin
        #2;
        if (ram_we) begin
            weCount++;
            weInfo = {ram_addr, ram_mode, ram_wdata};
        end
        if (nRamWe) begin
            nWeCount++;
            nWeInfo = {nRamAddr, nRamMode, nRamWdata};
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 4096; i++) modelMem[i] = 8'h00;
        expLoad = 0; expStore = 0; expErr = 0;
        nExpLoad = 0; nExpStore = 0; nExpErr = 0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, " load_cnt"}, 64'(load_cnt), 64'(expLoad));
        checkOutput({tag, " store_cnt"}, 64'(store_cnt), 64'(expStore));
        checkOutput({tag, " err_cnt"}, 64'(err_cnt), 64'(expErr));
        checkOutput({tag, " narrow load_cnt"}, 64'(nLoadCnt), 64'(nExpLoad));
        checkOutput({tag, " narrow store_cnt"}, 64'(nStoreCnt), 64'(nExpStore));
        checkOutput({tag, " narrow err_cnt"}, 64'(nErrCnt), 64'(nExpErr));
    endtask

    task automatic doClr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        resetModel();
    endtask

    // One complete request: accept, latency, optional back-pressure with junk requests, release, counters.
    task automatic applyStimulus(input bit we, input logic [1:0] size, input bit sgn, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int hold, input bit junk);
        bit bad;
        int nBytes, lat, we0, nwe0;
        longint v;
        logic [31:0] expData;
        bad = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) || (addr >= 32'h1000);
        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        expData = 32'h0;
        if (!bad && !we) begin
            v = 0;
            for (int i = nBytes - 1; i >= 0; i--) v = v * 256 + longint'(modelMem[addr[11:0] + 12'(i)]);
            if (sgn && nBytes < 4 && v >= (longint'(1) << (8 * nBytes - 1))) v -= (longint'(1) << (8 * nBytes));
            expData = 32'(v);
        end
        if (!bad && we) begin
            for (int i = 0; i < nBytes; i++) modelMem[addr[11:0] + 12'(i)] = wdata[8 * i +: 8];
        end

        @(negedge clk);
        checkOutput("req_ready idle", 64'(req_ready), 64'd1);
        checkOutput("narrow req_ready idle", 64'(nReqReady), 64'd1);
        we0 = weCount;
        nwe0 = nWeCount;
        req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("resp latency", 64'(lat), bad ? 64'd0 : 64'd1);
        checkOutput("resp_valid", 64'(resp_valid), 64'd1);
        checkOutput("narrow resp_valid", 64'(nRespValid), 64'd1);
        checkOutput("resp_err", 64'(resp_err), 64'(bad));
        checkOutput("resp_rdata", 64'(resp_rdata), 64'(expData));
        checkOutput("narrow resp_rdata", 64'(nRespRdata), 64'(expData));
        checkOutput("ram_we pulses", 64'(weCount - we0), (!bad && we) ? 64'd1 : 64'd0);
        checkOutput("narrow ram_we pulses", 64'(nWeCount - nwe0), (!bad && we) ? 64'd1 : 64'd0);
        if (!bad && we) begin
            checkOutput("ram write addr/mode/data", 64'(weInfo), 64'({addr[11:0], size, wdata}));
            checkOutput("narrow ram write", 64'(nWeInfo), 64'({addr[11:0], size, wdata}));
        end
        obsData = resp_rdata;

        for (int k = 0; k < hold; k++) begin
            if (junk) begin
                req_valid = 1'b1;
                req_we = 1'($urandom);
                req_size = 2'($urandom);
                req_addr = $urandom_range(0, 63);
                req_wdata = $urandom;
            end
            @(negedge clk);
            checkOutput("held resp_valid", 64'(resp_valid), 64'd1);
            checkOutput("held resp_rdata", 64'(resp_rdata), 64'(expData));
            checkOutput("held resp_err", 64'(resp_err), 64'(bad));
            checkOutput("held req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;

        if (bad) begin
            expErr = (expErr < 65535) ? expErr + 1 : 65535;
            nExpErr = (nExpErr < (1 << NW) - 1) ? nExpErr + 1 : (1 << NW) - 1;
        end else if (we) begin
            expStore = (expStore + 1) % 65536;
            nExpStore = (nExpStore + 1) % (1 << NW);
        end else begin
            expLoad = (expLoad + 1) % 65536;
            nExpLoad = (nExpLoad + 1) % (1 << NW);
        end
        checkOutput("resp_valid after release", 64'(resp_valid), 64'd0);
        checkOutput("req_ready after release", 64'(req_ready), 64'd1);
        checkCounters("after release");
    endtask

    initial begin
        int r, we0;
        logic [1:0] sz;
        logic [31:0] ad;

        clr = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset req_ready", 64'(req_ready), 64'd1);
        checkOutput("reset resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("reset resp_err", 64'(resp_err), 64'd0);
        checkOutput("reset resp_rdata", 64'(resp_rdata), 64'd0);
        checkOutput("reset ram_we", 64'(ram_we), 64'd0);
        checkOutput("reset ram_mode", 64'(ram_mode), 64'd2);
        checkOutput("reset ram_addr", 64'(ram_addr), 64'd0);
        checkOutput("reset ram_wdata", 64'(ram_wdata), 64'd0);
        checkCounters("reset");

        $display("[TB] halfword store then signed load");
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h006, 32'h1234_ABCD, 0, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h006, 32'h0, 0, 1'b0);
        checkOutput("lh 0x006 value", 64'(obsData), 64'hFFFF_ABCD);
        checkOutput("store_cnt after sh", 64'(store_cnt), 64'd1);
        checkOutput("load_cnt after lh", 64'(load_cnt), 64'd1);

        $display("[TB] signed and unsigned byte loads");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h000, 32'h80FF_7F01, 0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h003, 32'h0, 0, 1'b0);
        checkOutput("lb 0x003 value", 64'(obsData), 64'hFFFF_FF80);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h003, 32'h0, 0, 1'b0);
        checkOutput("lbu 0x003 value", 64'(obsData), 64'h0000_0080);

        $display("[TB] misaligned and out-of-range");
        doClr();
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h002, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h001, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
        checkOutput("err_cnt after three errors", 64'(err_cnt), 64'd3);

        $display("[TB] back-pressure");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h020, 32'hCAFE_F00D, 0, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, 5, 1'b1);
        checkOutput("lw after back-pressure", 64'(obsData), 64'hCAFE_F00D);

        $display("[TB] clr in ACCESS");
        @(negedge clk);
        we0 = weCount;
        req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h010; req_wdata = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        checkOutput("ram_we suppressed by clr", 64'(weCount - we0), 64'd0);
        checkOutput("no resp after clr", 64'(resp_valid), 64'd0);
        clr = 1'b0;
        resetModel();
        checkCounters("after clr");
        @(negedge clk);
        checkOutput("req_ready after clr", 64'(req_ready), 64'd1);
        checkOutput("resp_valid after clr", 64'(resp_valid), 64'd0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            ad = ($urandom_range(0, 7) == 0) ? 32'h1000 + $urandom_range(0, 40) : 32'($urandom_range(0, 31));
            applyStimulus(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 3), 1'($urandom));
        end

        $display("[TB] counter boundaries");
        doClr();
        for (int n = 0; n < (1 << NW) + 1; n++) applyStimulus(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 0, 1'b0);
        checkOutput("narrow err_cnt saturates", 64'(nErrCnt), 64'hF);
        checkOutput("wide err_cnt counts on", 64'(err_cnt), 64'd17);
        for (int n = 0; n < (1 << NW); n++) applyStimulus(1'b0, 2'd2, 1'b0, 32'h000, 32'h0, 0, 1'b0);
        checkOutput("narrow load_cnt wraps", 64'(nLoadCnt), 64'h0);
        checkOutput("wide load_cnt", 64'(load_cnt), 64'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
